// File: rtl/fifo_ctrl_param_if.sv
// Handshake and status bundle between a FIFO and the stages around it.
// The slave side is the FIFO itself; the master side is the producer/consumer.
interface fifo_ctrl_param_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 2
);
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  push, pop, flush, err_clr, data_in,
    output data_out, data_valid, fifo_full, fifo_empty,
           almost_full, almost_empty, count, overflow, underflow
  );

  modport master (
    output push, pop, flush, err_clr, data_in,
    input  data_out, data_valid, fifo_full, fifo_empty,
           almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module fifo_ctrl_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 2,
  parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic clk,
  input  logic rst,
  fifo_ctrl_param_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] C_AF    = AF_THRESH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] C_AE    = AE_THRESH[DEPTH_LOG2:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_ovf_event;
  logic w_udf_event;

  // Flags come only from the registered count, so push/pop never reach outputs.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // Flush swallows push/pop entirely, including their error side effects.
  assign w_push_ok   = bus.push & ~w_full  & ~bus.flush;
  assign w_pop_ok    = bus.pop  & ~w_empty & ~bus.flush;
  assign w_ovf_event = bus.push &  w_full  & ~bus.flush;
  assign w_udf_event = bus.pop  &  w_empty & ~bus.flush;

  // Storage is deliberately unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read port: data_out only moves on an accepted pop and otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_data_out <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
      end
    end
  end

  // Sticky errors; a fresh event in the clear cycle wins over err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_event) begin
        r_overflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_udf_event) begin
        r_underflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.data_valid   = r_data_valid;
  assign bus.fifo_full    = w_full;
  assign bus.fifo_empty   = w_empty;
  assign bus.almost_full  = (r_count >= C_AF);
  assign bus.almost_empty = (r_count <= C_AE);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Directed self-checking bench for fifo_ctrl_param at DEPTH = 4.
// Expected values are hand-computed for each step of the sequence.
module tb_fifo_ctrl_param;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;

  fifo_ctrl_param_if #(.DATA_WIDTH(16), .DEPTH_LOG2(2)) bus ();

  fifo_ctrl_param #(
    .DATA_WIDTH(16),
    .DEPTH_LOG2(2),
    .AF_THRESH (3),
    .AE_THRESH (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // One clock of stimulus; inputs return to idle and outputs are settled afterwards.
  task automatic applyStimulus(input logic p, input logic q, input logic f,
                               input logic e, input logic [15:0] d);
    bus.push    = p;
    bus.pop     = q;
    bus.flush   = f;
    bus.err_clr = e;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    bus.data_in = 16'h0000;
  endtask

  task automatic pushWord(input logic [15:0] d, input int expCount);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, d);
    checkOutput("push_count", 32'(bus.count), 32'(expCount));
  endtask

  task automatic popWord(input logic [15:0] expData, input int expCount);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("pop_data", 32'(bus.data_out), 32'(expData));
    checkOutput("pop_valid", 32'(bus.data_valid), 32'd1);
    checkOutput("pop_count", 32'(bus.count), 32'(expCount));
  endtask

  initial begin
    checkCount  = 0;
    failCount   = 0;
    rst         = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    bus.data_in = 16'h0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset and idle");
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_empty", 32'(bus.fifo_empty), 32'd1);
    checkOutput("rst_aempty", 32'(bus.almost_empty), 32'd1);
    checkOutput("rst_full", 32'(bus.fifo_full), 32'd0);
    checkOutput("rst_afull", 32'(bus.almost_full), 32'd0);
    checkOutput("rst_valid", 32'(bus.data_valid), 32'd0);
    checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("rst_udf", 32'(bus.underflow), 32'd0);

    $display("[TB] fill and drain");
    pushWord(16'h00A1, 1);
    checkOutput("fill_aempty1", 32'(bus.almost_empty), 32'd1);
    pushWord(16'h00A2, 2);
    checkOutput("fill_aempty2", 32'(bus.almost_empty), 32'd0);
    checkOutput("fill_afull2", 32'(bus.almost_full), 32'd0);
    pushWord(16'h00A3, 3);
    checkOutput("fill_afull3", 32'(bus.almost_full), 32'd1);
    checkOutput("fill_full3", 32'(bus.fifo_full), 32'd0);
    pushWord(16'h00A4, 4);
    checkOutput("fill_full4", 32'(bus.fifo_full), 32'd1);
    popWord(16'h00A1, 3);
    popWord(16'h00A2, 2);
    popWord(16'h00A3, 1);
    popWord(16'h00A4, 0);
    checkOutput("drain_empty", 32'(bus.fifo_empty), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("idle_valid", 32'(bus.data_valid), 32'd0);
    checkOutput("idle_hold", 32'(bus.data_out), 32'h00A4);

    $display("[TB] wrap-around");
    pushWord(16'h0011, 1);
    pushWord(16'h0012, 2);
    pushWord(16'h0013, 3);
    popWord(16'h0011, 2);
    popWord(16'h0012, 1);
    popWord(16'h0013, 0);
    pushWord(16'h00B1, 1);
    pushWord(16'h00B2, 2);
    pushWord(16'h00B3, 3);
    checkOutput("wrap_full3", 32'(bus.fifo_full), 32'd0);
    pushWord(16'h00B4, 4);
    checkOutput("wrap_full4", 32'(bus.fifo_full), 32'd1);
    popWord(16'h00B1, 3);
    popWord(16'h00B2, 2);
    popWord(16'h00B3, 1);
    popWord(16'h00B4, 0);

    $display("[TB] push and pop while full");
    pushWord(16'h00C1, 1);
    pushWord(16'h00C2, 2);
    pushWord(16'h00C3, 3);
    pushWord(16'h00C4, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h00CC);
    checkOutput("fullpp_count", 32'(bus.count), 32'd3);
    checkOutput("fullpp_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("fullpp_data", 32'(bus.data_out), 32'h00C1);
    popWord(16'h00C2, 2);
    popWord(16'h00C3, 1);
    popWord(16'h00C4, 0);

    $display("[TB] push and pop while empty");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h00DD);
    checkOutput("emptypp_count", 32'(bus.count), 32'd1);
    checkOutput("emptypp_udf", 32'(bus.underflow), 32'd1);
    checkOutput("emptypp_valid", 32'(bus.data_valid), 32'd0);
    popWord(16'h00DD, 0);

    $display("[TB] flush and error clear");
    pushWord(16'h00E1, 1);
    pushWord(16'h00E2, 2);
    pushWord(16'h00E3, 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h00EE);
    checkOutput("flush_count", 32'(bus.count), 32'd0);
    checkOutput("flush_empty", 32'(bus.fifo_empty), 32'd1);
    checkOutput("flush_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("flush_valid", 32'(bus.data_valid), 32'd0);
    checkOutput("flush_hold", 32'(bus.data_out), 32'h00DD);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("clr_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("clr_udf", 32'(bus.underflow), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("flushpop_udf", 32'(bus.underflow), 32'd0);
    checkOutput("flushpop_count", 32'(bus.count), 32'd0);
    pushWord(16'h00F1, 1);
    pushWord(16'h00F2, 2);
    pushWord(16'h00F3, 3);
    pushWord(16'h00F4, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h00FF);
    checkOutput("clrset_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("clrset_count", 32'(bus.count), 32'd4);
    popWord(16'h00F1, 3);
    popWord(16'h00F2, 2);

    $display("[TB] async reset mid-burst");
    bus.pop = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    checkOutput("arst_count", 32'(bus.count), 32'd0);
    checkOutput("arst_empty", 32'(bus.fifo_empty), 32'd1);
    checkOutput("arst_valid", 32'(bus.data_valid), 32'd0);
    checkOutput("arst_data", 32'(bus.data_out), 32'd0);
    checkOutput("arst_ovf", 32'(bus.overflow), 32'd0);
    @(posedge clk);
    bus.pop = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("arst_rel_valid", 32'(bus.data_valid), 32'd0);
    checkOutput("arst_rel_count", 32'(bus.count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
